// File: rtl/ffnn_pkg.sv
// Shared types and arithmetic helpers for the two-layer fixed-point FFNN core.
package ffnn_pkg;

    // Controller phases of one inference
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        L1       = 4'd1,
        L1_DRAIN = 4'd2,
        ACT1     = 4'd3,
        L2       = 4'd4,
        L2_DRAIN = 4'd5,
        ACT2     = 4'd6,
        ARGMAX   = 4'd7,
        DONE     = 4'd8
    } state_t;

    // Accumulator width: full product width plus enough headroom for the longest dot product
    function automatic int acc_width(input int dw, input int n_in, input int n_hid);
        int longest;
        longest = (n_in > n_hid) ? n_in : n_hid;
        return 2 * dw + $clog2(longest) + 1;
    endfunction

    // Scale down by 2^frac, then clamp to the unsigned dw-bit range (ReLU plus saturation)
    function automatic logic signed [63:0] act_sat(input logic signed [63:0] a,
                                                   input int dw, input int frac);
        logic signed [63:0] shifted;
        logic signed [63:0] ceiling;
        shifted = a >>> frac;
        ceiling = (64'sd1 <<< dw) - 64'sd1;
        if (shifted < 64'sd0) begin
            return 64'sd0;
        end else if (shifted > ceiling) begin
            return ceiling;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/ffnn_if.sv
// Input stream, weight-memory port and result handshake of the FFNN core.
interface ffnn_if #(
    parameter int DW    = 8,
    parameter int NLANE = 10,
    parameter int AW    = 7,
    parameter int CW    = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic                w_rd_en;
    logic [AW-1:0]       w_addr;
    logic [NLANE*DW-1:0] w_data;
    logic                out_valid;
    logic                out_ready;
    logic [CW-1:0]       out_class;
    logic [DW-1:0]       out_score;
    logic                busy;

    // Environment side: feeds features, serves weight rows, consumes results
    modport master (
        output in_valid, in_data, w_data, out_ready,
        input  in_ready, w_rd_en, w_addr, out_valid, out_class, out_score, busy
    );

    // Core side
    modport slave (
        input  in_valid, in_data, w_data, out_ready,
        output in_ready, w_rd_en, w_addr, out_valid, out_class, out_score, busy
    );
endinterface

// File: rtl/ffnn_lane.sv
// One neuron lane: signed multiply-accumulate with load/accumulate control and activation.
module ffnn_lane
    import ffnn_pkg::*;
#(
    parameter int DW    = 8,
    parameter int FRAC  = 4,
    parameter int ACC_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic signed [DW:0]   i_x,
    input  logic signed [DW-1:0] i_w,
    output logic [DW-1:0]        o_act
);
    logic signed [2*DW:0]   w_x_ext;
    logic signed [2*DW:0]   w_w_ext;
    logic signed [2*DW:0]   w_prod;
    logic signed [ACC_W-1:0] r_acc;

    // Both operands widened to the product width so the multiply is exact and signed
    assign w_x_ext = {{DW{i_x[DW]}}, i_x};
    assign w_w_ext = {{(DW+1){i_w[DW-1]}}, i_w};
    assign w_prod  = w_x_ext * w_w_ext;

    // Accumulator: first term of a dot product overwrites, later terms add, idle cycles hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_load ? ACC_W'(w_prod) : (r_acc + ACC_W'(w_prod));
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_act = DW'(act_sat(64'(r_acc), DW, FRAC));

endmodule

// File: rtl/ffnn_pipe.sv
// Two-layer fixed-point feed-forward classifier: streams features through NLANE
// MAC lanes, applies ReLU/saturation, reuses the lanes for layer 2, then argmax.
module ffnn_pipe
    import ffnn_pkg::*;
#(
    parameter int N_IN  = 63,
    parameter int N_HID = 10,
    parameter int N_OUT = 10,
    parameter int DW    = 8,
    parameter int FRAC  = 4
) (
    input logic   clk,
    input logic   rst_n,
    ffnn_if.slave bus
);
    localparam int NLANE   = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int AW      = $clog2(N_IN + N_HID);
    localparam int CW      = $clog2(N_OUT);
    localparam int ACC_W   = acc_width(DW, N_IN, N_HID);
    localparam int CNT_MAX = (N_IN > NLANE) ? N_IN : NLANE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic signed [DW:0]   r_x;
    logic                 r_mac_v;
    logic                 r_mac_load;
    logic                 r_layer2;
    logic [DW-1:0]        r_hidden [N_HID];
    logic [DW-1:0]        r_score  [N_OUT];
    logic [CW-1:0]        r_best_idx;
    logic [DW-1:0]        r_best_val;
    logic                 r_out_valid;
    logic [CW-1:0]        r_out_class;
    logic [DW-1:0]        r_out_score;

    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_rd_en;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_hid_sel;
    logic [DW-1:0]        w_score_sel;
    logic [NLANE-1:0]     w_lane_en;
    logic [DW-1:0]        w_lane_act [NLANE];

    assign w_in_ready = (r_state == IDLE) || (r_state == L1);
    assign w_xfer     = bus.in_valid && w_in_ready && rst_n;

    // Weight fetch: one row per accepted beat in layer 1, one row per cycle in layer 2
    always_comb begin
        w_rd_en = 1'b0;
        w_addr  = '0;
        case (r_state)
            IDLE: begin
                w_rd_en = w_xfer;
                w_addr  = '0;
            end
            L1: begin
                w_rd_en = w_xfer;
                w_addr  = AW'(r_cnt);
            end
            L2: begin
                w_rd_en = 1'b1;
                w_addr  = AW'(N_IN) + AW'(r_cnt);
            end
            default: begin
                w_rd_en = 1'b0;
                w_addr  = '0;
            end
        endcase
    end

    // Operand selectors: hidden activation feeding layer 2, score under argmax scan
    always_comb begin
        w_hid_sel   = '0;
        w_score_sel = '0;
        for (int j = 0; j < N_HID; j++) begin
            w_hid_sel = (r_cnt == CNT_W'(j)) ? r_hidden[j] : w_hid_sel;
        end
        for (int j = 0; j < N_OUT; j++) begin
            w_score_sel = (r_cnt == CNT_W'(j)) ? r_score[j] : w_score_sel;
        end
    end

    for (genvar j = 0; j < NLANE; j++) begin : g_lane
        localparam logic IN_L1 = (j < N_HID);
        localparam logic IN_L2 = (j < N_OUT);

        assign w_lane_en[j] = r_mac_v && (r_layer2 ? IN_L2 : IN_L1);

        ffnn_lane #(
            .DW    (DW),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_lane_en[j]),
            .i_load (r_mac_load),
            .i_x    (r_x),
            .i_w    (bus.w_data[j*DW +: DW]),
            .o_act  (w_lane_act[j])
        );
    end

    // Inference controller; the MAC operand is registered so it lines up with the weight row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_mac_v     <= 1'b0;
            r_mac_load  <= 1'b0;
            r_layer2    <= 1'b0;
            r_best_idx  <= '0;
            r_best_val  <= '0;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_score <= '0;
            for (int j = 0; j < N_HID; j++) r_hidden[j] <= '0;
            for (int j = 0; j < N_OUT; j++) r_score[j]  <= '0;
        end else begin
            r_mac_v    <= 1'b0;
            r_mac_load <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_x        <= {1'b0, bus.in_data};
                        r_mac_v    <= 1'b1;
                        r_mac_load <= 1'b1;
                        r_layer2   <= 1'b0;
                        r_cnt      <= CNT_W'(1);
                        r_state    <= (N_IN == 1) ? L1_DRAIN : L1;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                L1: begin
                    if (w_xfer) begin
                        r_x     <= {1'b0, bus.in_data};
                        r_mac_v <= 1'b1;
                        if (r_cnt == CNT_W'(N_IN - 1)) begin
                            r_cnt   <= '0;
                            r_state <= L1_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                L1_DRAIN: begin
                    r_state <= ACT1;
                end
                ACT1: begin
                    for (int j = 0; j < N_HID; j++) r_hidden[j] <= w_lane_act[j];
                    r_cnt   <= '0;
                    r_state <= L2;
                end
                L2: begin
                    r_x        <= {1'b0, w_hid_sel};
                    r_mac_v    <= 1'b1;
                    r_mac_load <= (r_cnt == '0);
                    r_layer2   <= 1'b1;
                    if (r_cnt == CNT_W'(N_HID - 1)) begin
                        r_cnt   <= '0;
                        r_state <= L2_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                L2_DRAIN: begin
                    r_state <= ACT2;
                end
                ACT2: begin
                    for (int j = 0; j < N_OUT; j++) r_score[j] <= w_lane_act[j];
                    r_cnt   <= '0;
                    r_state <= ARGMAX;
                end
                ARGMAX: begin
                    // Strictly-greater replacement keeps the lowest index on ties
                    if ((r_cnt == '0) || (w_score_sel > r_best_val)) begin
                        r_best_idx <= CW'(r_cnt);
                        r_best_val <= w_score_sel;
                    end else begin
                        r_best_val <= r_best_val;
                    end
                    if (r_cnt == CNT_W'(N_OUT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; it then holds until accepted
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_class <= r_best_idx;
                        r_out_score <= r_best_val;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.w_rd_en   = w_rd_en;
    assign bus.w_addr    = w_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_class = r_out_class;
    assign bus.out_score = r_out_score;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ffnn_pipe.sv
// Scoreboard bench for ffnn_pipe with a small 4-2-3 network and directed vectors.
module tb_ffnn_pipe;
    localparam int N_IN  = 4;
    localparam int N_HID = 2;
    localparam int N_OUT = 3;
    localparam int DW    = 8;
    localparam int FRAC  = 4;
    localparam int NLANE = 3;
    localparam int AW    = 3;
    localparam int CW    = 2;
    localparam int LAT   = N_HID + N_OUT + 5;

    typedef struct {
        int cls;
        int score;
    } exp_t;
    typedef logic [DW-1:0] vec_t [N_IN];

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ffnn_if #(.DW(DW), .NLANE(NLANE), .AW(AW), .CW(CW)) bus ();

    ffnn_pipe #(
        .N_IN  (N_IN),
        .N_HID (N_HID),
        .N_OUT (N_OUT),
        .DW    (DW),
        .FRAC  (FRAC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Weight memory with one-cycle read latency
    logic [NLANE*DW-1:0] wmem [N_IN+N_HID];
    always @(posedge clk) begin
        if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];
    end

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   t_acc    = 0;
    exp_t exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: pops the scoreboard when a result appears, then checks it holds
    exp_t cur;
    logic prev_valid = 1'b0;
    bit   have_cur   = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            have_cur   = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) begin
                check("result_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("out_class", int'(bus.out_class), cur.cls);
                    check("out_score", int'(bus.out_score), cur.score);
                    check("latency", cyc - t_acc, LAT);
                end
            end else if (bus.out_valid && have_cur) begin
                check("hold_class", int'(bus.out_class), cur.cls);
                check("hold_score", int'(bus.out_score), cur.score);
                check("hold_in_ready", int'(bus.in_ready), 0);
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic set_weights(input int w1, input int a, input int b, input int c);
        for (int r = 0; r < N_IN; r++) wmem[r] = {DW'(w1), DW'(w1), DW'(w1)};
        for (int r = N_IN; r < N_IN + N_HID; r++) wmem[r] = {DW'(c), DW'(b), DW'(a)};
    endtask

    task automatic send_beat(input int k, input logic [DW-1:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("in_ready", int'(bus.in_ready), 1);
        check("w_rd_en_beat", int'(bus.w_rd_en), 1);
        check("w_addr_beat", int'(bus.w_addr), k);
        @(posedge clk);
        #1;
        t_acc        = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check("w_rd_en_gap", int'(bus.w_rd_en), 0);
        end
    endtask

    task automatic run_inf(input vec_t d, input int gap, input int cls, input int score);
        exp_t e;
        e.cls   = cls;
        e.score = score;
        exp_q.push_back(e);
        for (int k = 0; k < N_IN; k++) begin
            send_beat(k, d[k]);
            if (k < N_IN - 1) idle_gap(gap);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("return_idle", int'(bus.busy), 0);
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_class", int'(bus.out_class), 0);
        check("rst_out_score", int'(bus.out_score), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_w_rd_en", int'(bus.w_rd_en), 0);
        check("rst_w_addr", int'(bus.w_addr), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1234;
        vec_t vmax;
        int   guard;
        v1234 = '{8'd1, 8'd2, 8'd3, 8'd4};
        vmax  = '{8'd255, 8'd255, 8'd255, 8'd255};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        set_weights(16, 16, 16, 16);

        #3 rst_n = 1'b0;
        #1 check_reset_state();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All weights 16: hidden 10,10 -> scores 20,20,20, tie resolves to class 0
        run_inf(v1234, 0, 0, 20);
        wait_idle();

        // Layer-2 lanes 0,1 negative: scores 0,0,20 -> class 2
        set_weights(16, -16, -16, 16);
        run_inf(v1234, 0, 2, 20);
        wait_idle();

        // Tie between lanes 1 and 2 after a clamped lane 0 -> lowest tied index
        set_weights(16, -16, 16, 16);
        run_inf(v1234, 0, 1, 20);
        wait_idle();

        // Saturation: acc 129540 in layer 1, every activation clamps to 255
        set_weights(127, 127, 127, 127);
        run_inf(vmax, 0, 0, 255);
        wait_idle();

        // Input gaps and a stalled consumer: result must hold unchanged in DONE
        set_weights(16, 16, 16, 16);
        bus.out_ready = 1'b0;
        run_inf(v1234, 2, 0, 20);
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("stall_valid_seen", int'(bus.out_valid), 1);
        repeat (10) @(negedge clk);
        check("stall_valid_held", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        wait_idle();
        check("stall_valid_dropped", int'(bus.out_valid), 0);

        // Reset during layer 2 aborts the inference with no result
        run_inf(v1234, 0, 0, 20);
        repeat (3) @(negedge clk);
        check("l2_busy", int'(bus.busy), 1);
        check("l2_w_rd_en", int'(bus.w_rd_en), 1);
        check("l2_w_addr", int'(bus.w_addr), N_IN);
        rst_n = 1'b0;
        #1 check_reset_state();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_valid", int'(bus.out_valid), 0);

        // Full inference after the abort
        run_inf(v1234, 0, 0, 20);
        wait_idle();

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ffnn_pipe.md
FFNN_PIPE -- requirements
Module: ffnn_pipe

Interface
REQ-001 Parameter N_IN, default 63: input features per inference.
REQ-002 Parameter N_HID, default 10: hidden neurons.
REQ-003 Parameter N_OUT, default 10: output classes.
REQ-004 Parameter DW, default 8: data and weight width.
REQ-005 Parameter FRAC, default 4: fixed-point right shift applied before activation.
REQ-006 Derived: NLANE = max(N_HID,N_OUT); AW = clog2(N_IN+N_HID); CW = clog2(N_OUT); ACC_W = 2*DW + clog2(max(N_IN,N_HID)) + 1.
REQ-007 clk  in  1  single clock; all state changes on the rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 in_valid  in  1  input beat valid.
REQ-010 in_ready  out  1  core accepts input beat.
REQ-011 in_data  in  DW  unsigned input feature.
REQ-012 w_rd_en  out  1  weight read strobe.
REQ-013 w_addr  out  AW  weight row address.
REQ-014 w_data  in  NLANE*DW  signed weight row; lane j in bits [j*DW +: DW]; valid one cycle after w_rd_en.
REQ-015 out_valid  out  1  result valid.
REQ-016 out_ready  in  1  result accepted.
REQ-017 out_class  out  CW  winning class index.
REQ-018 out_score  out  DW  winning activation.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 States SHALL be: IDLE, L1, L1_DRAIN, ACT1, L2, L2_DRAIN, ACT2, ARGMAX, DONE.
REQ-021 in_ready SHALL be 1 in IDLE and L1 only.
REQ-022 A beat transfers when in_valid && in_ready; the first beat moves IDLE->L1 and loads, rather than adds, every accumulator.
REQ-023 Beat k (0..N_IN-1) SHALL drive w_rd_en=1 and w_addr=k in its transfer cycle; input is registered, and lane j accumulates in_data*w_data[j] on the next cycle for j<N_HID.
REQ-024 Cycles without a transfer SHALL keep w_rd_en=0 and accumulators unchanged; input gaps of any length are legal.
REQ-025 After beat N_IN-1: L1->L1_DRAIN (1 cycle), then ACT1 (1 cycle), which stores hidden[j]=act(acc[j]).
REQ-026 act(a) SHALL be: 0 if (a>>>FRAC)<0, 2^DW-1 if (a>>>FRAC)>2^DW-1, else a>>>FRAC (arithmetic shift), yielding an unsigned DW-bit value.
REQ-027 L2 SHALL last N_HID cycles; cycle m issues w_addr=N_IN+m; lane j<N_OUT accumulates hidden[m]*w_data[j], loading at m=0.
REQ-028 L2_DRAIN (1 cycle), then ACT2 (1 cycle), which stores score[j]=act(acc[j]).
REQ-029 ARGMAX SHALL scan one lane per cycle for N_OUT cycles, replacing the best only on strictly greater, so ties resolve to the lowest index.
REQ-030 out_valid SHALL rise exactly N_HID+N_OUT+5 cycles after the edge accepting the last input beat.
REQ-031 In DONE, out_valid, out_class and out_score SHALL hold stable until out_ready=1; on that edge the core goes to IDLE and out_valid drops.
REQ-032 out_ready while out_valid=0 SHALL have no effect.
REQ-033 Products are signed(DW+1) x signed(DW); accumulators are ACC_W signed and SHALL never overflow at the parameter limits.

Reset
REQ-034 rst=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, out_class=0, out_score=0, busy=0, w_rd_en=0, w_addr=0, and clear all accumulators, hidden and score registers.
REQ-035 Reset in any state aborts the inference; no partial result is ever presented.

Structure
REQ-036 Package ffnn_pkg SHALL hold the state enum, the ACC_W calculation function and the act() saturate/ReLU function.
REQ-037 Sub-module ffnn_lane (MAC accumulator plus act) SHALL be instantiated NLANE times.

Verification (N_IN=4, N_HID=2, N_OUT=3, DW=8, FRAC=4 unless stated)
REQ-038 All weights 16, inputs 1,2,3,4 -> hidden 10,10; scores 20,20,20; out_class=0, out_score=20.
REQ-039 Layer-1 weights 16; layer-2 lane 2 weights +16 and lanes 0,1 weights -16 -> scores 0,0,20; out_class=2, out_score=20.
REQ-040 Inputs 255, all weights 127 -> acc 129540, hidden saturates to 255; out_score=255, out_class=0.
REQ-041 Two-cycle gaps between input beats and out_ready held low 10 cycles -> same result as REQ-038; out_valid and outputs stable, in_ready=0 throughout DONE.
REQ-042 rst pulsed low during L2 -> out_valid=0, busy=0 immediately; the next full inference yields the REQ-038 result.
REQ-043 Latency check -> out_valid rises exactly 10 cycles after the last input beat.
